// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the architectural register file / rename tag table.
// Default widths match the Tomasulo core: 32 x 32-bit registers, 4-bit ROB tags.
package reg_rename_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_WIDTH  = 5;
    localparam int ROB_WIDTH  = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
    localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

endpackage

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register pending ROB tags.
// Define REGFILE_COMMIT_BYPASS_EN to forward same-cycle commits onto the read ports.
module reg_rename_file
    import reg_rename_file_pkg::*;
#(
    parameter int DATA_WIDTH = reg_rename_file_pkg::DATA_WIDTH,
    parameter int REG_WIDTH  = reg_rename_file_pkg::REG_WIDTH,
    parameter int ROB_WIDTH  = reg_rename_file_pkg::ROB_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_ena,
    input  logic                  in_flush,
    input  logic [REG_WIDTH-1:0]  in_commit_reg,
    input  logic [ROB_WIDTH-1:0]  in_commit_rob,
    input  logic [DATA_WIDTH-1:0] in_commit_value,
    input  logic                  in_rename_ena,
    input  logic [REG_WIDTH-1:0]  in_rename_reg,
    input  logic [ROB_WIDTH-1:0]  in_rename_tag,
    input  logic [REG_WIDTH-1:0]  in_query_reg1,
    input  logic [REG_WIDTH-1:0]  in_query_reg2,
    output logic [DATA_WIDTH-1:0] out_value1,
    output logic [DATA_WIDTH-1:0] out_value2,
    output logic [ROB_WIDTH-1:0]  out_tag1,
    output logic [ROB_WIDTH-1:0]  out_tag2
);

    localparam int NUM_REGS = 1 << REG_WIDTH;

    logic [DATA_WIDTH-1:0] value_q [NUM_REGS];
    logic [ROB_WIDTH-1:0]  tag_q   [NUM_REGS];

    logic commit_hit;
    logic rename_hit;

    assign commit_hit = in_ena && (in_commit_reg != '0);
    assign rename_hit = in_ena && in_rename_ena && (in_rename_reg != '0);

    // x0 is never written, so its entries stay at their reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            if (commit_hit) begin
                value_q[in_commit_reg] <= in_commit_value;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (in_ena) begin
                    if (in_flush) begin
                        tag_q[i] <= '0;
                    end else if (rename_hit &&
                                 in_rename_reg == REG_WIDTH'(i)) begin
                        tag_q[i] <= in_rename_tag;
                    end else if (commit_hit &&
                                 in_commit_reg == REG_WIDTH'(i) &&
                                 tag_q[i] == in_commit_rob) begin
                        tag_q[i] <= '0;
                    end
                end
            end
        end
    end

    function automatic logic [DATA_WIDTH+ROB_WIDTH-1:0] read_port(
        input logic [REG_WIDTH-1:0] q
    );
        logic [DATA_WIDTH-1:0] v;
        logic [ROB_WIDTH-1:0]  t;
        v = value_q[q];
        t = tag_q[q];
        if (q == '0) begin
            v = '0;
            t = '0;
        end
`ifdef REGFILE_COMMIT_BYPASS_EN
        // A same-cycle rename of q keeps reporting stored state.
        else if (rst && commit_hit && q == in_commit_reg &&
                 tag_q[q] == in_commit_rob &&
                 !(rename_hit && in_rename_reg == q)) begin
            v = in_commit_value;
            t = '0;
        end
`endif
        return {v, t};
    endfunction

    always_comb begin
        {out_value1, out_tag1} = read_port(in_query_reg1);
        {out_value2, out_tag2} = read_port(in_query_reg2);
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed table-driven bench for reg_rename_file.
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_ena;
    logic        in_flush;
    logic [4:0]  in_commit_reg;
    logic [3:0]  in_commit_rob;
    logic [31:0] in_commit_value;
    logic        in_rename_ena;
    logic [4:0]  in_rename_reg;
    logic [3:0]  in_rename_tag;
    logic [4:0]  in_query_reg1;
    logic [4:0]  in_query_reg2;
    logic [31:0] out_value1;
    logic [31:0] out_value2;
    logic [3:0]  out_tag1;
    logic [3:0]  out_tag2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_rename_file dut (
        .clk(clk),
        .rst(rst),
        .in_ena(in_ena),
        .in_flush(in_flush),
        .in_commit_reg(in_commit_reg),
        .in_commit_rob(in_commit_rob),
        .in_commit_value(in_commit_value),
        .in_rename_ena(in_rename_ena),
        .in_rename_reg(in_rename_reg),
        .in_rename_tag(in_rename_tag),
        .in_query_reg1(in_query_reg1),
        .in_query_reg2(in_query_reg2),
        .out_value1(out_value1),
        .out_value2(out_value2),
        .out_tag1(out_tag1),
        .out_tag2(out_tag2)
    );

    // Outputs are checked before the edge, so expectations reflect
    // the state left by the previous rows.
    typedef struct {
        logic        ena;
        logic        flush;
        logic [4:0]  creg;
        logic [3:0]  crob;
        logic [31:0] cval;
        logic        ren;
        logic [4:0]  rreg;
        logic [3:0]  rtag;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic [31:0] ev1;
        logic [3:0]  et1;
        logic [31:0] ev2;
        logic [3:0]  et2;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_ena          = v.ena;
        in_flush        = v.flush;
        in_commit_reg   = v.creg;
        in_commit_rob   = v.crob;
        in_commit_value = v.cval;
        in_rename_ena   = v.ren;
        in_rename_reg   = v.rreg;
        in_rename_tag   = v.rtag;
        in_query_reg1   = v.q1;
        in_query_reg2   = v.q2;
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        in_ena          = 1'b1;
        in_flush        = 1'b0;
        in_commit_reg   = 5'd0;
        in_commit_rob   = 4'd0;
        in_commit_value = 32'd0;
        in_rename_ena   = 1'b0;
        in_rename_reg   = 5'd0;
        in_rename_tag   = 4'd0;
        in_query_reg1   = q1;
        in_query_reg2   = q2;
    endtask

    initial begin
        // ena flush creg crob cval ren rreg rtag q1 q2 ev1 et1 ev2 et2
        vecs.push_back('{1,0, 0,0,32'h0,        1, 5,3, 5,0, 32'h0,0,        32'h0,0});
        vecs.push_back('{1,0, 5,3,32'hDEADBEEF, 0, 0,0, 5,0, 32'h0,3,        32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        0, 0,0, 5,0, 32'hDEADBEEF,0, 32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        1, 5,3, 5,0, 32'hDEADBEEF,0, 32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        1, 5,7, 5,0, 32'hDEADBEEF,3, 32'h0,0});
        vecs.push_back('{1,0, 5,3,32'h11,       0, 0,0, 5,0, 32'hDEADBEEF,7, 32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        0, 0,0, 5,0, 32'h11,7,       32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        1, 8,2, 8,0, 32'h0,0,        32'h0,0});
        vecs.push_back('{1,0, 8,2,32'h22,       1, 8,9, 8,0, 32'h0,2,        32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        0, 0,0, 8,5, 32'h22,9,       32'h11,7});
        vecs.push_back('{1,0, 0,0,32'h0,        1, 1,4, 1,0, 32'h0,0,        32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        1, 2,6, 1,2, 32'h0,4,        32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        1, 3,1, 2,3, 32'h0,6,        32'h0,0});
        vecs.push_back('{1,1, 1,4,32'h55,       1, 9,5, 1,3, 32'h0,4,        32'h0,1});
        vecs.push_back('{1,0, 0,0,32'h0,        0, 0,0, 1,2, 32'h55,0,       32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        0, 0,0, 3,9, 32'h0,0,        32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h99,       1, 0,5, 0,8, 32'h0,0,        32'h22,0});
        vecs.push_back('{1,0, 0,0,32'h0,        0, 0,0, 0,5, 32'h0,0,        32'h11,0});
        vecs.push_back('{0,1, 1,0,32'h77,       1, 4,2, 1,4, 32'h55,0,       32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        0, 0,0, 1,4, 32'h55,0,       32'h0,0});
        vecs.push_back('{1,0, 0,0,32'h0,        1, 6,5, 6,0, 32'h0,0,        32'h0,0});

        // Reset held low while writes are attempted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle(5, 6);
            in_commit_reg   = 5'd5;
            in_commit_value = 32'hA5A5_0000 + i;
            in_rename_ena   = 1'b1;
            in_rename_reg   = 5'd6;
            in_rename_tag   = 4'd3;
            #1;
            check("reset_v5", out_value1, 32'h0);
            check("reset_t5", {28'd0, out_tag1}, 32'h0);
            check("reset_t6", {28'd0, out_tag2}, 32'h0);
        end
        @(negedge clk);
        idle(5, 6);
        #1;
        check("after_reset_v5", out_value1, 32'h0);
        check("after_reset_t6", {28'd0, out_tag2}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d_v1", i), out_value1, vecs[i].ev1);
            check($sformatf("row%0d_t1", i), {28'd0, out_tag1},
                  {28'd0, vecs[i].et1});
            check($sformatf("row%0d_v2", i), out_value2, vecs[i].ev2);
            check($sformatf("row%0d_t2", i), {28'd0, out_tag2},
                  {28'd0, vecs[i].et2});
        end

        // tag[6] = 5: commit x6 and observe same cycle and next cycle.
        @(negedge clk);
        idle(6, 0);
        in_commit_reg   = 5'd6;
        in_commit_rob   = 4'd5;
        in_commit_value = 32'hAB;
        #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        check("byp_same_v", out_value1, 32'hAB);
        check("byp_same_t", {28'd0, out_tag1}, 32'h0);
`else
        check("byp_same_v", out_value1, 32'h0);
        check("byp_same_t", {28'd0, out_tag1}, 32'h5);
`endif
        @(negedge clk);
        idle(6, 0);
        in_rename_ena = 1'b1;
        in_rename_reg = 5'd6;
        in_rename_tag = 4'd5;
        #1;
        check("byp_next_v", out_value1, 32'hAB);
        check("byp_next_t", {28'd0, out_tag1}, 32'h0);

        // Disabled commit of x6 with a matching tag changes nothing.
        @(negedge clk);
        idle(6, 0);
        in_ena          = 1'b0;
        in_commit_reg   = 5'd6;
        in_commit_rob   = 4'd5;
        in_commit_value = 32'hCD;
        #1;
        check("noena_same_v", out_value1, 32'hAB);
        check("noena_same_t", {28'd0, out_tag1}, 32'h5);
        @(negedge clk);
        idle(6, 0);
        #1;
        check("noena_next_v", out_value1, 32'hAB);
        check("noena_next_t", {28'd0, out_tag1}, 32'h5);

        // Asynchronous reset clears state without a clock edge.
        rst = 1'b0;
        #1;
        check("async_rst_v6", out_value1, 32'h0);
        check("async_rst_t6", {28'd0, out_tag1}, 32'h0);
        in_query_reg1 = 5'd5;
        #1;
        check("async_rst_v5", out_value1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
